// File: rtl/ysyx_22050710_lsu_pkg.sv
// Shared types and helpers for the load/store stage: MemOP codes, access size,
// FSM states and the size-to-byte-lane mask.
package ysyx_22050710_lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_BU = 3'b001;
  localparam logic [2:0] MEMOP_H  = 3'b010;
  localparam logic [2:0] MEMOP_HU = 3'b011;
  localparam logic [2:0] MEMOP_W  = 3'b100;
  localparam logic [2:0] MEMOP_WU = 3'b101;
  localparam logic [2:0] MEMOP_D  = 3'b110;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_e;

  // Signed and unsigned variants share a size; extension happens downstream.
  function automatic size_e memop_size(input logic [2:0] op);
    case (op)
      MEMOP_B, MEMOP_BU: return SZ_B;
      MEMOP_H, MEMOP_HU: return SZ_H;
      MEMOP_W, MEMOP_WU: return SZ_W;
      MEMOP_D:           return SZ_D;
      default:           return SZ_D;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Byte-lane alignment: store data/mask placement, misalignment check and
// right-alignment of load data within one 8-byte word.
module ysyx_22050710_lsu_align
  import ysyx_22050710_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_off,
  input  size_e           i_size,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wdata,
  output logic [7:0]      o_wmask,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_rdata
);

  logic [7:0]      lane;
  logic [XLEN-1:0] rshift;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    lane         = size_mask(i_size);
    o_wmask      = lane << i_off;
    o_wdata      = i_wdata << {i_off, 3'b000};
    rshift       = i_rdata >> {i_off, 3'b000};
    o_rdata      = '0;
    o_misaligned = 1'b0;
    for (int i = 0; i < XLEN / 8; i++) begin
      o_rdata[8*i +: 8] = rshift[8*i +: 8] & {8{lane[i]}};
    end
    case (i_size)
      SZ_H:    o_misaligned = i_off[0];
      SZ_W:    o_misaligned = |i_off[1:0];
      SZ_D:    o_misaligned = |i_off;
      default: o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050710_lsu.sv
// Multi-cycle load/store stage: one memory access per request over a
// valid/ready interface, with misalignment and response-timeout errors.
module ysyx_22050710_lsu
  import ysyx_22050710_lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [2:0]      i_MemOP,
  input  logic            i_MemRd,
  input  logic            i_MemWr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_rdata,
  output logic [XLEN-1:0] o_addr,
  output logic            o_err,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [7:0]      o_mem_wmask,
  input  logic            i_mem_rsp_valid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [7:0]        wmask_q, wmask_d;
  size_e             size_q, size_d;
  logic              wen_q, wen_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        al_off;
  size_e             al_size;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic [7:0]        al_wmask;
  logic              al_misaligned;

  // In IDLE the aligner sees the incoming request; afterwards the captured one.
  always_comb begin
    al_off  = addr_q[2:0];
    al_size = size_q;
    if (state_q == ST_IDLE) begin
      al_off  = i_addr[2:0];
      al_size = memop_size(i_MemOP);
    end
  end

  ysyx_22050710_lsu_align #(.XLEN(XLEN)) u_align (
    .i_off        (al_off),
    .i_size       (al_size),
    .i_wdata      (i_wdata),
    .i_rdata      (i_mem_rdata),
    .o_wdata      (al_wdata),
    .o_wmask      (al_wmask),
    .o_misaligned (al_misaligned),
    .o_rdata      (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wmask_d = wmask_q;
    size_d  = size_q;
    wen_d   = wen_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          addr_d  = i_addr;
          size_d  = memop_size(i_MemOP);
          wen_d   = i_MemWr;
          wdata_d = al_wdata;
          wmask_d = i_MemWr ? al_wmask : 8'h00;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!i_MemRd && !i_MemWr) begin
            state_d = ST_DONE;
          end else if (al_misaligned) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the timeout cycle still completes normally.
        if (i_mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : al_rdata;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wmask_q <= '0;
      size_q  <= SZ_B;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wmask_q <= wmask_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready         = (state_q == ST_IDLE);
  assign o_valid         = (state_q == ST_DONE);
  assign o_mem_req_valid = (state_q == ST_REQ);
  assign o_rdata         = rdata_q;
  assign o_addr          = addr_q;
  assign o_err           = err_q;
  assign o_mem_addr      = {addr_q[XLEN-1:3], 3'b000};
  assign o_mem_wen       = wen_q;
  assign o_mem_wdata     = wdata_q;
  assign o_mem_wmask     = wmask_q;

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// Directed-vector bench for the load/store stage with hand-computed expectations.
module tb_ysyx_22050710_lsu;

  localparam int TO = 8;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_addr;
  logic [63:0] i_wdata;
  logic [2:0]  i_MemOP;
  logic        i_MemRd;
  logic        i_MemWr;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_rdata;
  logic [63:0] o_addr;
  logic        o_err;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [63:0] o_mem_addr;
  logic        o_mem_wen;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_rsp_valid;
  logic [63:0] i_mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_22050710_lsu #(.XLEN(64), .TIMEOUT_CYC(TO)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .i_MemOP         (i_MemOP),
    .i_MemRd         (i_MemRd),
    .i_MemWr         (i_MemWr),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_rdata         (o_rdata),
    .o_addr          (o_addr),
    .o_err           (o_err),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wen       (o_mem_wen),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_wmask     (o_mem_wmask),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rdata     (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [2:0] op, input logic rd, input logic wr);
    i_valid = 1'b1;
    i_addr  = addr;
    i_wdata = wdata;
    i_MemOP = op;
    i_MemRd = rd;
    i_MemWr = wr;
  endtask

  // One full transaction. rsp_wait = RESP cycle index carrying the response
  // (-1 = never); exp_mem = 0 means no memory request may appear.
  task automatic access(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [2:0] op, input logic rd, input logic wr,
                        input int req_wait, input int rsp_wait, input int done_wait,
                        input logic [63:0] mem_data, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                        input logic exp_err, input logic exp_mem);
    check({tag, "/ready_at_accept"}, 64'(o_ready), 64'd1);
    drive(addr, wdata, op, rd, wr);
    @(negedge i_clk);
    i_valid = 1'b0;
    if (exp_mem) begin
      for (int i = 0; i <= req_wait; i++) begin
        check({tag, "/req_valid"}, 64'(o_mem_req_valid), 64'd1);
        check({tag, "/mem_addr"}, o_mem_addr, {addr[63:3], 3'b000});
        check({tag, "/mem_wen"}, 64'(o_mem_wen), 64'(wr));
        check({tag, "/mem_wmask"}, 64'(o_mem_wmask), 64'(exp_mask));
        check({tag, "/mem_wdata"}, o_mem_wdata, exp_wdata);
        check({tag, "/req_busy"}, {62'd0, o_ready, o_valid}, 64'd0);
        i_mem_req_ready = (i == req_wait);
        @(negedge i_clk);
      end
      i_mem_req_ready = 1'b0;
      for (int k = 0; k < TO; k++) begin
        check({tag, "/resp_quiet"}, {62'd0, o_mem_req_valid, o_valid}, 64'd0);
        if (k == rsp_wait) begin
          i_mem_rsp_valid = 1'b1;
          i_mem_rdata     = mem_data;
        end
        @(negedge i_clk);
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = '0;
        if (k == rsp_wait) break;
      end
    end
    for (int j = 0; j <= done_wait; j++) begin
      check({tag, "/o_valid"}, 64'(o_valid), 64'd1);
      check({tag, "/o_err"}, 64'(o_err), 64'(exp_err));
      check({tag, "/o_rdata"}, o_rdata, exp_rdata);
      check({tag, "/o_addr"}, o_addr, addr);
      check({tag, "/done_busy"}, {62'd0, o_ready, o_mem_req_valid}, 64'd0);
      i_ready = (j == done_wait);
      @(negedge i_clk);
    end
    i_ready = 1'b0;
    check({tag, "/back_idle"}, {62'd0, o_ready, o_valid}, 64'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_MemOP = '0; i_MemRd = 1'b0; i_MemWr = 1'b0;
    i_ready = 1'b0; i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rdata = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    check("rst/ready", 64'(o_ready), 64'd1);
    check("rst/ctl", {60'd0, o_valid, o_err, o_mem_req_valid, o_mem_wen}, 64'd0);
    check("rst/rdata", o_rdata, 64'd0);
    check("rst/addr", o_addr, 64'd0);
    check("rst/mem_addr", o_mem_addr, 64'd0);
    check("rst/mem_wdata", o_mem_wdata, 64'd0);
    check("rst/mem_wmask", 64'(o_mem_wmask), 64'd0);

    //      tag       addr                   wdata                  op    rd    wr   rq rs dn mem_data               mask   exp_wdata              exp_rdata              err  mem
    access("sb",     64'h8000_0003, 64'h0000_0000_0000_00AB, 3'b000, 1'b0, 1'b1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h08, 64'h0000_0000_AB00_0000, 64'h0, 1'b0, 1'b1);
    access("lh",     64'h8000_0006, 64'h0, 3'b010, 1'b1, 1'b0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 64'h0000_0000_0000_1234, 1'b0, 1'b1);
    access("lbu",    64'h8000_0001, 64'h0, 3'b001, 1'b1, 1'b0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 64'h0000_0000_0000_00DE, 1'b0, 1'b1);
    access("lwu",    64'h8000_0004, 64'h0, 3'b101, 1'b1, 1'b0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 64'h0000_0000_1234_5678, 1'b0, 1'b1);
    access("ld",     64'h8000_0008, 64'h0, 3'b110, 1'b1, 1'b0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
    access("lb",     64'h8000_0007, 64'h0, 3'b000, 1'b1, 1'b0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 64'h0000_0000_0000_0012, 1'b0, 1'b1);
    access("sw",     64'h8000_0004, 64'h1122_3344_5566_7788, 3'b100, 1'b0, 1'b1, 0, 0, 0, 64'h0, 8'hF0, 64'h5566_7788_0000_0000, 64'h0, 1'b0, 1'b1);
    access("sd",     64'h8000_0010, 64'hCAFE_BABE_DEAD_BEEF, 3'b110, 1'b0, 1'b1, 0, 0, 0, 64'h0, 8'hFF, 64'hCAFE_BABE_DEAD_BEEF, 64'h0, 1'b0, 1'b1);
    access("sh",     64'h8000_0002, 64'h0000_0000_0000_BEEF, 3'b010, 1'b0, 1'b1, 0, 0, 0, 64'h0, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0, 1'b0, 1'b1);
    access("rdwr",   64'h8000_0006, 64'h0000_0000_0000_A5A5, 3'b011, 1'b1, 1'b1, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'hC0, 64'hA5A5_0000_0000_0000, 64'h0, 1'b0, 1'b1);
    access("bypass", 64'h0000_1234, 64'h0, 3'b000, 1'b0, 1'b0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0);
    access("mis_lw", 64'h8000_0002, 64'h0, 3'b100, 1'b1, 1'b0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
    access("mis_sh", 64'h8000_0001, 64'h0000_0000_0000_1111, 3'b010, 1'b0, 1'b1, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
    access("mis_ld", 64'h8000_0004, 64'h0, 3'b110, 1'b1, 1'b0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
    access("mis_hu", 64'h8000_0003, 64'h0, 3'b011, 1'b1, 1'b0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
    access("bp_sw",  64'h8000_000C, 64'h0000_0000_1122_3344, 3'b100, 1'b0, 1'b1, 4, 0, 5, 64'h0, 8'hF0, 64'h1122_3344_0000_0000, 64'h0, 1'b0, 1'b1);
    access("bp_ld",  64'h8000_0018, 64'h0, 3'b110, 1'b1, 1'b0, 4, 2, 5, 64'h0102_0304_0506_0708, 8'h00, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 1'b1);
    access("tmo",    64'h8000_0020, 64'h0, 3'b100, 1'b1, 1'b0, 0, -1, 0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b1);
    access("tmo_rsp",64'h8000_0024, 64'h0, 3'b100, 1'b1, 1'b0, 0, TO-1, 0, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 64'h0000_0000_1234_5678, 1'b0, 1'b1);

    // Reset while waiting in RESP: the late response must be ignored.
    check("rstresp/ready", 64'(o_ready), 64'd1);
    drive(64'h8000_0030, 64'h0, 3'b100, 1'b1, 1'b0);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("rstresp/req_valid", 64'(o_mem_req_valid), 64'd1);
    i_mem_req_ready = 1'b1;
    @(negedge i_clk);
    i_mem_req_ready = 1'b0;
    check("rstresp/in_resp", {62'd0, o_ready, o_mem_req_valid}, 64'd0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rstresp/ready_after", 64'(o_ready), 64'd1);
    check("rstresp/ctl_after", {60'd0, o_valid, o_err, o_mem_req_valid, o_mem_wen}, 64'd0);
    check("rstresp/addr_after", o_addr, 64'd0);
    i_mem_rsp_valid = 1'b1;
    i_mem_rdata     = 64'h1234_5678_9ABC_DEF0;
    @(negedge i_clk);
    i_mem_rsp_valid = 1'b0;
    i_mem_rdata     = '0;
    for (int i = 0; i < 3; i++) begin
      check("rstresp/no_valid", {62'd0, o_valid, o_ready}, 64'd1);
      check("rstresp/rdata", o_rdata, 64'd0);
      @(negedge i_clk);
    end
    access("post_rst", 64'h8000_0030, 64'h0, 3'b100, 1'b1, 1'b0, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 8'h00, 64'h0, 64'h0000_0000_CCCC_DDDD, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_lsu.md
Name: ysyx_22050710_lsu

Overview:
Multi-cycle load/store stage directly downstream of the execute unit. It takes the ALU result as the effective address, plus rs2 store data and MemOP/read/write controls. It performs one access over a valid/ready memory interface and returns right-aligned, unextended read data for the MemOP sign/zero-extension mux and the write-back path. It replaces the single-cycle ideal memory, adds misalignment detection and a response timeout, and applies back-pressure upstream while busy.

Parameters:
XLEN, 64, datapath and address width
TIMEOUT_CYC, 1023, maximum cycles to wait for a memory response before flagging an error (must be at least 1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  upstream request valid
o_ready  out  1  stage can accept a request (high only in IDLE)
i_addr  in  XLEN  effective address (ALU result)
i_wdata  in  XLEN  store data (rs2)
i_MemOP  in  3  000 b, 001 bu, 010 h, 011 hu, 100 w, 101 wu, 110 d
i_MemRd  in  1  load
i_MemWr  in  1  store
o_valid  out  1  result valid to downstream
i_ready  in  1  downstream accepts result
o_rdata  out  XLEN  loaded bytes right-aligned; bytes above access size are zero
o_addr  out  XLEN  registered copy of i_addr, passed through
o_err  out  1  misaligned access or timeout; qualified by o_valid
o_mem_req_valid  out  1  memory request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_addr  out  XLEN  i_addr with bits [2:0] cleared
o_mem_wen  out  1  1 = write
o_mem_wdata  out  XLEN  store data shifted to its byte lanes
o_mem_wmask  out  8  byte-lane enables; 0 for reads
i_mem_rsp_valid  in  1  read data or write acknowledge
i_mem_rdata  in  XLEN  8-byte-aligned read data

Behaviour:
- Single clock i_clk; i_rst is synchronous and active-high.
- Reset: state IDLE. o_ready=1. o_valid, o_err, o_mem_req_valid and o_mem_wen are 0. All data outputs are 0. Timeout counter is 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: when i_valid and o_ready are both high, capture all inputs and compute size, lane mask and shifted wdata. Next state:
  - neither MemRd nor MemWr: DONE, o_rdata=0, o_err=0 (pass-through);
  - misaligned (h with addr[0]≠0; w with addr[1:0]≠0; d with addr[2:0]≠0): DONE, o_err=1, no memory request issued;
  - otherwise: REQ.
- If MemRd and MemWr are both set, the store takes precedence.
- REQ: o_mem_req_valid=1 with addr, wen, wdata and wmask held stable until i_mem_req_ready. On that handshake go to RESP and clear the counter.
- RESP: counter increments each cycle.
  - On i_mem_rsp_valid: for a load, o_rdata = (i_mem_rdata >> 8*addr[2:0]) masked to the access size; for a store, o_rdata=0. Go to DONE with o_err=0.
  - If the counter reaches TIMEOUT_CYC-1 with no response: go to DONE with o_err=1 and o_rdata=0.
  - If a response and the timeout land in the same cycle, the response wins.
- DONE: o_valid=1 and all outputs held stable until i_ready, then IDLE. No bypass: a new request is accepted at the earliest one cycle after the DONE handshake.
- Minimum latency, accept to o_valid:
  - 1 cycle for bypass or error;
  - 3 cycles for a memory access with zero-wait handshakes.
- Store lanes: b mask 0x01, h 0x03, w 0x0F, d 0xFF, each shifted left by addr[2:0]. wdata is shifted left by 8*addr[2:0].
- MemOP 001/011/101 decode size exactly as 000/010/100. Extension is downstream's job.
- i_mem_rsp_valid is ignored outside RESP.
- i_rst in any state returns to the reset values next cycle. Any outstanding memory transaction is abandoned and its late response is ignored.
- At most one transaction is in flight.

Decomposition:
- Shared package holds:
  - MemOP encodings;
  - size enum (B/H/W/D);
  - FSM state typedef;
  - a size-to-lane-mask constant function.
- One combinational sub-module, ysyx_22050710_lsu_align, produces:
  - shifted wdata and wmask;
  - misalignment flag;
  - right-aligned, size-masked rdata.

Test Plan:
1. sb: addr 0x8000_0003, wdata 0xAB → o_mem_addr 0x8000_0000, wmask 0x08, wdata[31:24]=0xAB, wen=1; rsp → o_valid, o_err=0, o_rdata=0.
2. lh: addr 0x8000_0006, mem rdata 0x1234_5678_9ABC_DEF0 → o_rdata 0x0000_0000_0000_1234; o_valid exactly 3 cycles after accept with zero-wait memory.
3. lw at 0x8000_0002 → o_mem_req_valid never asserts; o_valid=1, o_err=1 one cycle after accept.
4. Back-pressure: i_mem_req_ready low 4 cycles then i_ready low 5 cycles → req fields stable throughout; o_valid/o_rdata held; o_ready=0 until the DONE handshake.
5. TIMEOUT_CYC=8, no response → o_valid with o_err=1 exactly 8 cycles after entering RESP; response on that same cycle → o_err=0 with data.
6. i_rst while in RESP → next cycle IDLE, o_ready=1, o_valid=0; a subsequent i_mem_rsp_valid produces no o_valid.
